// File: rtl/t03_load_store_unit_if.sv
// Cache/memory bus between the load/store unit (master) and memory (slave).
// One req/ack transaction at a time; rdata is valid in the ack cycle.
interface t03_load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_sel,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_sel,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/t03_load_store_unit.sv
// Memory stage behind the ALU: one bus transaction per load/store, stalling the
// core until it completes, with byte-lane steering and load extension.
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write; illegal accesses are rejected here
// REQ   | bus_req held until bus_ack or TIMEOUT request cycles
// DONE  | one-cycle completion pulse, core advances PC
module t03_load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] rd2,
  t03_load_store_unit_if.master bus,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err_align,
  output logic        err_timeout
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [1:0]    b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   load_data_q, load_data_d;
  logic          err_align_q, err_align_d;
  logic          err_timeout_q, err_timeout_d;

  logic          access;
  logic          legal;
  logic [1:0]    b_in;
  logic [3:0]    sel_in;
  logic [31:0]   wdata_in;
  logic [31:0]   shifted;
  logic [31:0]   load_ext;

  // Decode the incoming access: legality, byte enables and replicated store data.
  always_comb begin
    access   = mem_read | mem_write;
    b_in     = alu_result[1:0];
    legal    = 1'b1;
    sel_in   = 4'b1111;
    wdata_in = rd2;
    if (funct3[1:0] == 2'b11) legal = 1'b0;
    // Unsigned variants exist only for byte/half loads.
    if (funct3[2] && (mem_write || funct3[1:0] == 2'b10)) legal = 1'b0;
    if (funct3[1:0] == 2'b01 && b_in[0]) legal = 1'b0;
    if (funct3[1:0] == 2'b10 && b_in != 2'b00) legal = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        sel_in   = 4'b0001 << b_in;
        wdata_in = {4{rd2[7:0]}};
      end
      2'b01: begin
        sel_in   = 4'b0011 << b_in;
        wdata_in = {2{rd2[15:0]}};
      end
      default: begin
        sel_in   = 4'b1111;
        wdata_in = rd2;
      end
    endcase
  end

  // Align the read word to the accessed lane and extend to 32 bits.
  always_comb begin
    shifted = bus.bus_rdata >> {b_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // Next-state and register updates for the transaction FSM.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    we_d          = we_q;
    sel_d         = sel_q;
    wdata_d       = wdata_q;
    funct3_d      = funct3_q;
    b_d           = b_q;
    cnt_d         = cnt_q;
    load_data_d   = load_data_q;
    err_align_d   = 1'b0;
    err_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (legal) begin
            state_d  = REQ;
            addr_d   = {alu_result[31:2], 2'b00};
            we_d     = mem_write;
            sel_d    = sel_in;
            wdata_d  = wdata_in;
            funct3_d = funct3;
            b_d      = b_in;
            cnt_d    = '0;
          end else begin
            err_align_d = 1'b1;
          end
        end
      end
      REQ: begin
        // An ack in the last allowed cycle wins over the timeout.
        if (bus.bus_ack) begin
          if (!we_q) load_data_d = load_ext;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          if (!we_q) load_data_d = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; async reset clears everything.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      we_q          <= 1'b0;
      sel_q         <= '0;
      wdata_q       <= '0;
      funct3_q      <= '0;
      b_q           <= '0;
      cnt_q         <= '0;
      load_data_q   <= '0;
      err_align_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      sel_q         <= sel_d;
      wdata_q       <= wdata_d;
      funct3_q      <= funct3_d;
      b_q           <= b_d;
      cnt_q         <= cnt_d;
      load_data_q   <= load_data_d;
      err_align_q   <= err_align_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Outputs decode from state so bus_req/stall drop as soon as reset asserts.
  always_comb begin
    bus.bus_req   = (state_q == REQ);
    bus.bus_we    = (state_q == REQ) & we_q;
    bus.bus_addr  = addr_q;
    bus.bus_wdata = wdata_q;
    bus.bus_sel   = sel_q;
    stall         = ((state_q == IDLE) & access & legal) | (state_q == REQ);
    done          = (state_q == DONE);
    load_data     = load_data_q;
    err_align     = err_align_q;
    err_timeout   = err_timeout_q;
  end

endmodule

// File: tb/tb_t03_load_store_unit.sv
// Self-checking bench for t03_load_store_unit with TIMEOUT=8.
module tb_t03_load_store_unit;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        nrst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_result, rd2;
  logic        stall, done, err_align, err_timeout;
  logic [31:0] load_data;

  t03_load_store_unit_if bus_if ();

  t03_load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .nrst(nrst), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .alu_result(alu_result), .rd2(rd2), .bus(bus_if),
    .stall(stall), .done(done), .load_data(load_data),
    .err_align(err_align), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Observations of the last access
  int          r_req, r_stall, r_done, r_align, r_tout;
  bit          r_we, r_stable;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_sel;
  logic [31:0] ld_model;

  // ---------------- reference model ----------------
  function automatic bit m_legal(input bit wr, input logic [2:0] f3, input logic [1:0] b);
    int s;
    s = 1 << f3[1:0];
    if (f3[1:0] == 2'd3) return 1'b0;
    if (f3[2] && (wr || s == 4)) return 1'b0;
    return (int'(b) % s) == 0;
  endfunction

  function automatic logic [3:0] m_sel(input logic [2:0] f3, input logic [1:0] b);
    int s;
    s = 1 << f3[1:0];
    return 4'(((1 << s) - 1) << b);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'd0) return 32'(d[7:0]) * 32'h01010101;
    if (f3[1:0] == 2'd1) return 32'(d[15:0]) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] b, input logic [31:0] rdata);
    int s;
    longint v;
    s = 1 << f3[1:0];
    v = longint'(rdata >> (8 * int'(b)));
    if (s < 4) begin
      v = v % (longint'(1) << (8 * s));
      if (!f3[2] && v >= (longint'(1) << (8 * s - 1))) v = v - (longint'(1) << (8 * s));
    end
    return 32'(v);
  endfunction

  // ---------------- stimulus driver ----------------
  // ack_at: REQ cycle (1-based) on which to ack; 0 or > TO means never.
  task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] data,
                            input int ack_at, input logic [31:0] rdata);
    bit seen_done;
    r_req = 0; r_stall = 0; r_done = 0; r_align = 0; r_tout = 0;
    r_we = 0; r_stable = 1; r_addr = '0; r_wdata = '0; r_sel = '0;
    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; alu_result = addr; rd2 = data;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = rdata;
    #1;
    if (stall) r_stall++;
    seen_done = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0; bus_if.bus_ack = 1'b0;
      funct3 = 3'($urandom); alu_result = $urandom; rd2 = $urandom;
      #1;
      if (stall) r_stall++;
      if (err_align) r_align++;
      if (err_timeout) r_tout++;
      if (done) r_done++;
      if (bus_if.bus_req) begin
        r_req++;
        if (r_req == 1) begin
          r_addr = bus_if.bus_addr; r_wdata = bus_if.bus_wdata;
          r_sel = bus_if.bus_sel; r_we = bus_if.bus_we;
        end else if (bus_if.bus_addr !== r_addr || bus_if.bus_wdata !== r_wdata ||
                     bus_if.bus_sel !== r_sel || bus_if.bus_we !== r_we) begin
          r_stable = 0;
        end
        bus_if.bus_ack = (r_req == ack_at);
      end
      if (done) seen_done = 1;
      else if (seen_done) break;
      else if (r_req == 0 && !stall && cyc >= 2) break;
    end
    bus_if.bus_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    checks++;
    if ({bus_if.bus_req, bus_if.bus_we, stall, done, err_align, err_timeout} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000000",
        {bus_if.bus_req, bus_if.bus_we, stall, done, err_align, err_timeout});
    end
    checks++;
    if ({bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_sel, load_data} !== 100'b0) begin
      errors++; $display("FAIL reset_data addr=%h wdata=%h sel=%b ld=%h exp all zero",
        bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_sel, load_data);
    end
  endtask

  task automatic test_store_word();
    run_access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 3, 32'h0);
    checks++;
    if (r_addr !== 32'h100 || r_sel !== 4'b1111 || r_wdata !== 32'hDEADBEEF || r_we !== 1'b1) begin
      errors++; $display("FAIL sw_bus addr=%h sel=%b wdata=%h we=%b exp 100 1111 deadbeef 1",
        r_addr, r_sel, r_wdata, r_we);
    end
    checks++;
    if (r_stall != 4 || r_req != 3 || r_done != 1) begin
      errors++; $display("FAIL sw_timing stall=%0d req=%0d done=%0d exp 4 3 1", r_stall, r_req, r_done);
    end
    checks++;
    if (!r_stable || r_align != 0 || r_tout != 0 || load_data !== ld_model) begin
      errors++; $display("FAIL sw_misc stable=%0d align=%0d tout=%0d ld=%h exp 1 0 0 %h",
        r_stable, r_align, r_tout, load_data, ld_model);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] ads [5] = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h204};
    logic [31:0] exv [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h80FF1234};
    logic [3:0]  exs [5] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1111};
    for (int i = 0; i < 5; i++) begin
      run_access(1, 0, f3s[i], ads[i], $urandom, $urandom_range(1, 3), 32'h80FF1234);
      ld_model = exv[i];
      checks++;
      if (load_data !== exv[i]) begin
        errors++; $display("FAIL load_val[%0d] got %h exp %h", i, load_data, exv[i]);
      end
      checks++;
      if (r_sel !== exs[i] || r_addr !== {ads[i][31:2], 2'b00} || r_we !== 1'b0 || r_done != 1) begin
        errors++; $display("FAIL load_bus[%0d] sel=%b addr=%h we=%b done=%0d exp %b %h 0 1",
          i, r_sel, r_addr, r_we, r_done, exs[i], {ads[i][31:2], 2'b00});
      end
    end
  endtask

  task automatic test_align();
    run_access(0, 1, 3'b001, 32'h101, 32'h12345678, 1, 32'h0);
    checks++;
    if (r_align != 1 || r_req != 0 || r_stall != 0 || r_done != 0) begin
      errors++; $display("FAIL align_sh align=%0d req=%0d stall=%0d done=%0d exp 1 0 0 0",
        r_align, r_req, r_stall, r_done);
    end
    run_access(1, 0, 3'b010, 32'h102, 32'h0, 1, 32'h0);
    checks++;
    if (r_align != 1 || r_req != 0 || r_stall != 0 || r_done != 0) begin
      errors++; $display("FAIL align_lw align=%0d req=%0d stall=%0d done=%0d exp 1 0 0 0",
        r_align, r_req, r_stall, r_done);
    end
  endtask

  task automatic test_timeout();
    run_access(1, 0, 3'b010, 32'h300, 32'h0, 0, 32'h55AA55AA);
    ld_model = 32'h0;
    checks++;
    if (r_req != TO || r_tout != 1 || r_done != 1 || r_stall != TO + 1) begin
      errors++; $display("FAIL timeout_seq req=%0d tout=%0d done=%0d stall=%0d exp %0d 1 1 %0d",
        r_req, r_tout, r_done, r_stall, TO, TO + 1);
    end
    checks++;
    if (load_data !== 32'h0) begin
      errors++; $display("FAIL timeout_ld got %h exp 00000000", load_data);
    end
    run_access(1, 0, 3'b010, 32'h304, 32'h0, TO, 32'h13579BDF);
    ld_model = 32'h13579BDF;
    checks++;
    if (r_req != TO || r_tout != 0 || r_done != 1 || load_data !== 32'h13579BDF) begin
      errors++; $display("FAIL ack_last req=%0d tout=%0d done=%0d ld=%h exp %0d 0 1 13579bdf",
        r_req, r_tout, r_done, load_data, TO);
    end
  endtask

  task automatic test_write_wins();
    run_access(1, 1, 3'b000, 32'h401, 32'h000000A5, 1, 32'hFFFFFFFF);
    checks++;
    if (r_we !== 1'b1 || r_sel !== 4'b0010 || r_wdata !== 32'hA5A5A5A5 || load_data !== ld_model ||
        r_stall != 2) begin
      errors++; $display("FAIL write_wins we=%b sel=%b wdata=%h ld=%h stall=%0d exp 1 0010 a5a5a5a5 %h 2",
        r_we, r_sel, r_wdata, load_data, r_stall, ld_model);
    end
  endtask

  task automatic test_reset_mid_req();
    logic [31:0] d;
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; alu_result = 32'h500;
    @(negedge clk);
    mem_read = 1'b0;
    #1;
    checks++;
    if (bus_if.bus_req !== 1'b1) begin
      errors++; $display("FAIL mid_req_entry bus_req=%b exp 1", bus_if.bus_req);
    end
    #2 nrst = 1'b0;
    #1;
    ld_model = 32'h0;
    checks++;
    if (bus_if.bus_req !== 1'b0 || stall !== 1'b0 || load_data !== 32'h0) begin
      errors++; $display("FAIL mid_req_reset bus_req=%b stall=%b ld=%h exp 0 0 0",
        bus_if.bus_req, stall, load_data);
    end
    @(negedge clk);
    nrst = 1'b1;
    d = $urandom;
    run_access(0, 1, 3'b000, 32'h3, d, 2, 32'h0);
    checks++;
    if (r_sel !== 4'b1000 || r_wdata !== {4{d[7:0]}} || r_addr !== 32'h0 || r_done != 1) begin
      errors++; $display("FAIL sb_after_reset sel=%b wdata=%h addr=%h done=%0d exp 1000 %h 0 1",
        r_sel, r_wdata, r_addr, r_done, {4{d[7:0]}});
    end
  endtask

  task automatic test_random();
    bit rd, wr, lg;
    logic [2:0]  f3;
    logic [31:0] a, d, rdata;
    int ack, exp_req;
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom); rd = wr ? 1'($urandom) : 1'b1;
      f3 = 3'($urandom); a = $urandom; d = $urandom; rdata = $urandom;
      ack = $urandom_range(1, TO + 2);
      lg = m_legal(wr, f3, a[1:0]);
      run_access(rd, wr, f3, a, d, ack, rdata);
      checks++;
      if (!lg) begin
        if (r_align != 1 || r_req != 0 || r_stall != 0 || r_done != 0) begin
          errors++; $display("FAIL rnd_illegal[%0d] f3=%b a=%h align=%0d req=%0d stall=%0d done=%0d",
            i, f3, a, r_align, r_req, r_stall, r_done);
        end
        continue;
      end
      exp_req = (ack > TO) ? TO : ack;
      if (!wr) ld_model = (ack > TO) ? 32'h0 : m_load(f3, a[1:0], rdata);
      if (r_align != 0 || r_req != exp_req || r_stall != exp_req + 1 || r_done != 1 ||
          r_tout != int'(ack > TO)) begin
        errors++; $display("FAIL rnd_timing[%0d] align=%0d req=%0d stall=%0d done=%0d tout=%0d exp 0 %0d %0d 1 %0d",
          i, r_align, r_req, r_stall, r_done, r_tout, exp_req, exp_req + 1, int'(ack > TO));
      end
      checks++;
      if (r_addr !== {a[31:2], 2'b00} || r_sel !== m_sel(f3, a[1:0]) || r_we !== wr ||
          r_wdata !== m_wdata(f3, d) || !r_stable) begin
        errors++; $display("FAIL rnd_bus[%0d] addr=%h sel=%b we=%b wdata=%h stable=%0d exp %h %b %b %h 1",
          i, r_addr, r_sel, r_we, r_wdata, r_stable, {a[31:2], 2'b00}, m_sel(f3, a[1:0]), wr, m_wdata(f3, d));
      end
      checks++;
      if (load_data !== ld_model) begin
        errors++; $display("FAIL rnd_load[%0d] f3=%b b=%0d rdata=%h got %h exp %h",
          i, f3, a[1:0], rdata, load_data, ld_model);
      end
    end
  endtask

  initial begin
    nrst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
    alu_result = '0; rd2 = '0; bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
    ld_model = 32'h0;
    repeat (2) @(negedge clk);
    test_reset();
    nrst = 1'b1;
    test_store_word();
    test_loads();
    test_align();
    test_timeout();
    test_write_wins();
    test_reset_mid_req();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
